// File: rtl/fc_output_layer.sv
// fc_output_layer: fully connected output layer, one shared MAC unit.
// Evaluates HEIGHT neurons sequentially: each neuron streams WIDTH
// feature/weight pairs through the MAC, fetches its bias, then writes
// saturate((acc >>> FRAC) + bias) into result_layer[n].
//
// Ports:
//   clk, reset    - rising-edge clock, synchronous active-high reset
//   start         - request one layer evaluation (accepted only in IDLE)
//   feat_addr     - feature buffer read address
//   feat_data     - signed feature, valid one cycle after feat_addr
//   w_addr        - weight/bias ROM address (weights n*WIDTH+i, biases HEIGHT*WIDTH+n)
//   w_data        - signed weight or bias, valid one cycle after w_addr
//   result_layer  - signed neuron outputs, held between evaluations
//   busy          - high while an evaluation is in progress
//   done          - one-cycle pulse when result_layer is complete
module fc_output_layer #(
    parameter int BITS   = 24,
    parameter int HEIGHT = 10,
    parameter int WIDTH  = 64,
    parameter int FRAC   = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    output logic [$clog2(WIDTH)-1:0]              feat_addr,
    input  logic signed [BITS-1:0]                feat_data,
    output logic [$clog2(HEIGHT*WIDTH+HEIGHT)-1:0] w_addr,
    input  logic signed [BITS-1:0]                w_data,
    output logic signed [BITS-1:0]                result_layer [0:HEIGHT-1],
    output logic                                  busy,
    output logic                                  done
);

    localparam int FA   = $clog2(WIDTH);
    localparam int WA   = $clog2(HEIGHT*WIDTH+HEIGHT);
    localparam int ACCW = 2*BITS + $clog2(WIDTH);
    localparam int NW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int IW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;

    // Clamp bounds, sized to the post-bias sum.
    localparam logic signed [ACCW:0] SMAX = {{(ACCW+2-BITS){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [ACCW:0] SMIN = {{(ACCW+2-BITS){1'b1}}, {(BITS-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MAC, BIAS, WRITE, DONE} state_t;

    state_t                  state, state_nx;
    logic [NW-1:0]           n;
    logic [IW-1:0]           i;
    logic                    mac_en;
    logic signed [ACCW-1:0]  acc;
    logic                    last_i, last_n;
    logic signed [2*BITS-1:0] prod;
    logic signed [ACCW-1:0]  prod_ext;
    logic signed [ACCW-1:0]  shifted;
    logic signed [ACCW:0]    sum;
    logic signed [BITS-1:0]  sat;

    assign last_i = (i == IW'(WIDTH-1));
    assign last_n = (n == NW'(HEIGHT-1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        done      = 1'b0;
        feat_addr = '0;
        w_addr    = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = MAC;
            end
            MAC: begin
                feat_addr = FA'(i);
                w_addr    = WA'(n) * WA'(WIDTH) + WA'(i);
                if (last_i) state_nx = BIAS;
            end
            BIAS: begin
                w_addr   = WA'(HEIGHT*WIDTH) + WA'(n);
                state_nx = WRITE;
            end
            WRITE: begin
                state_nx = last_n ? DONE : MAC;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Product and scaled/saturated result. In WRITE, w_data carries the bias
    // fetched during BIAS.
    always_comb begin
        prod     = feat_data * w_data;
        prod_ext = {{(ACCW-2*BITS){prod[2*BITS-1]}}, prod};
        shifted  = acc >>> FRAC;
        sum      = {shifted[ACCW-1], shifted} + {{(ACCW+1-BITS){w_data[BITS-1]}}, w_data};
        if (sum > SMAX)      sat = SMAX[BITS-1:0];
        else if (sum < SMIN) sat = SMIN[BITS-1:0];
        else                 sat = sum[BITS-1:0];
    end

    // mac_en marks cycles whose read data belongs to an address issued in
    // MAC the cycle before, so the final product lands during BIAS.
    always_ff @(posedge clk) begin
        if (reset) begin
            n      <= '0;
            i      <= '0;
            mac_en <= 1'b0;
            acc    <= '0;
            for (int unsigned k = 0; k < HEIGHT; k++) result_layer[k] <= '0;
        end else begin
            mac_en <= (state == MAC);
            if (mac_en) acc <= acc + prod_ext;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        n   <= '0;
                        i   <= '0;
                    end
                end
                MAC: i <= i + 1'b1;
                WRITE: begin
                    result_layer[n] <= sat;
                    acc             <= '0;
                    i               <= '0;
                    if (!last_n) n <= n + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
